// File: rtl/checkpoint_sched_pkg.sv
// rtl/checkpoint_sched_pkg.sv - shared types and defaults for the checkpoint scheduler
package checkpoint_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } sched_state_t;

    typedef enum logic {
        REQ_SAVE    = 1'b0,
        REQ_RESTORE = 1'b1
    } req_type_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/ckpt_rr_arbiter.sv
// rtl/ckpt_rr_arbiter.sv - round-robin arbiter; priority moves to the index after each taken grant
module ckpt_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          update,
    output logic          grant_valid,
    output logic [IW-1:0] grant_idx
);
    localparam int PW = IW + 1;

    logic [IW-1:0] ptr;

    // Scan from the farthest offset down so the requester closest to ptr wins.
    always_comb begin
        logic [PW-1:0] pos;
        grant_valid = 1'b0;
        grant_idx   = '0;
        pos         = '0;
        for (int i = N - 1; i >= 0; i--) begin
            pos = {1'b0, ptr} + PW'(i);
            if (pos >= PW'(N))
                pos = pos - PW'(N);
            if (req[pos[IW-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = pos[IW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (update && grant_valid)
            ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end

endmodule

// File: rtl/checkpoint_scheduler.sv
// rtl/checkpoint_scheduler.sv - arbitrates save/restore requests and sequences them to the checkpoint controller
module checkpoint_scheduler
    import checkpoint_sched_pkg::*;
#(
    parameter int NUM_REQ          = 4,
    parameter int CHECKPOINT_DEPTH = 8,
    parameter int ID_W             = $clog2(CHECKPOINT_DEPTH),
    parameter int TIMEOUT_CYCLES   = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sched_enable,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_restore,
    input  logic [NUM_REQ*ID_W-1:0]     req_slot,
    output logic [NUM_REQ-1:0]          req_ack,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic                        rsp_ok,
    output logic [ID_W-1:0]             rsp_slot,
    output logic                        ckpt_trigger,
    output logic                        recov_trigger,
    output logic [ID_W-1:0]             ckpt_id,
    input  logic                        ckpt_complete,
    input  logic                        recov_complete,
    input  logic                        ckpt_failed,
    input  logic                        recov_failed,
    output logic [CHECKPOINT_DEPTH-1:0] slot_valid,
    output logic                        busy,
    output logic                        timeout_err,
    output logic [7:0]                  fail_count
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    sched_state_t    state;
    req_type_t       g_type;
    logic [GW-1:0]   g_idx;
    logic [ID_W-1:0] g_slot;
    logic [ID_W-1:0] wr_ptr;
    logic [TW-1:0]   wait_cnt;

    logic [NUM_REQ-1:0] rest_req;
    logic [NUM_REQ-1:0] save_req;
    logic               rest_gv;
    logic               save_gv;
    logic [GW-1:0]      rest_gidx;
    logic [GW-1:0]      save_gidx;
    logic [ID_W-1:0]    slot_of [NUM_REQ];

    logic               can_grant;
    logic               take_rest;
    logic               take_save;
    logic [GW-1:0]      pick_idx;
    logic [ID_W-1:0]    pick_slot;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [NUM_REQ-1:0] g_onehot;
    logic               done_hit;
    logic               fail_hit;
    logic               tmo_hit;
    logic [7:0]         fail_inc;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            slot_of[i] = req_slot[i*ID_W +: ID_W];
    end

    assign rest_req = req_valid & req_restore;
    assign save_req = req_valid & ~req_restore;

    ckpt_rr_arbiter #(.N(NUM_REQ), .IW(GW)) u_rest_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (rest_req),
        .update      (take_rest),
        .grant_valid (rest_gv),
        .grant_idx   (rest_gidx)
    );

    ckpt_rr_arbiter #(.N(NUM_REQ), .IW(GW)) u_save_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (save_req),
        .update      (take_save),
        .grant_valid (save_gv),
        .grant_idx   (save_gidx)
    );

    // Restores always beat saves; the save arbiter only advances when it actually wins.
    assign can_grant   = (state == ST_IDLE) && sched_enable;
    assign take_rest   = can_grant && rest_gv;
    assign take_save   = can_grant && !rest_gv && save_gv;
    assign pick_idx    = rest_gv ? rest_gidx : save_gidx;
    assign pick_slot   = rest_gv ? slot_of[pick_idx] : wr_ptr;
    assign pick_onehot = NUM_REQ'(1) << pick_idx;
    assign g_onehot    = NUM_REQ'(1) << g_idx;

    assign fail_hit = (g_type == REQ_RESTORE) ? recov_failed   : ckpt_failed;
    assign done_hit = (g_type == REQ_RESTORE) ? recov_complete : ckpt_complete;
    assign tmo_hit  = (wait_cnt == TO_LAST);
    assign fail_inc = (fail_count == 8'hFF) ? fail_count : fail_count + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            g_type        <= REQ_SAVE;
            g_idx         <= '0;
            g_slot        <= '0;
            wr_ptr        <= '0;
            wait_cnt      <= '0;
            req_ack       <= '0;
            rsp_valid     <= '0;
            rsp_ok        <= 1'b0;
            rsp_slot      <= '0;
            ckpt_trigger  <= 1'b0;
            recov_trigger <= 1'b0;
            ckpt_id       <= '0;
            slot_valid    <= '0;
            busy          <= 1'b0;
            timeout_err   <= 1'b0;
            fail_count    <= '0;
        end else begin
            req_ack       <= '0;
            rsp_valid     <= '0;
            ckpt_trigger  <= 1'b0;
            recov_trigger <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (take_rest || take_save) begin
                        g_idx  <= pick_idx;
                        g_slot <= pick_slot;
                        g_type <= take_rest ? REQ_RESTORE : REQ_SAVE;
                        busy   <= 1'b1;
                        if (take_rest && !slot_valid[pick_slot]) begin
                            // An empty slot is refused locally; the controller never sees it.
                            state      <= ST_RESP;
                            req_ack    <= pick_onehot;
                            rsp_valid  <= pick_onehot;
                            rsp_ok     <= 1'b0;
                            rsp_slot   <= pick_slot;
                            fail_count <= fail_inc;
                        end else begin
                            state         <= ST_ISSUE;
                            req_ack       <= pick_onehot;
                            ckpt_trigger  <= take_save;
                            recov_trigger <= take_rest;
                            ckpt_id       <= pick_slot;
                            if (take_save)
                                slot_valid[pick_slot] <= 1'b0;
                        end
                    end
                end
                ST_ISSUE: begin
                    state    <= ST_WAIT;
                    wait_cnt <= '0;
                end
                ST_WAIT: begin
                    if (fail_hit || done_hit || tmo_hit) begin
                        state     <= ST_RESP;
                        rsp_valid <= g_onehot;
                        rsp_slot  <= g_slot;
                        rsp_ok    <= done_hit && !fail_hit;
                        if (done_hit && !fail_hit) begin
                            if (g_type == REQ_SAVE) begin
                                slot_valid[g_slot] <= 1'b1;
                                wr_ptr <= (wr_ptr == ID_W'(CHECKPOINT_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
                            end
                        end else begin
                            fail_count <= fail_inc;
                            if (!fail_hit)
                                timeout_err <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_checkpoint_scheduler.sv
// tb/tb_checkpoint_scheduler.sv - directed and randomized checks against a transaction-level scheduler model
module tb_checkpoint_scheduler;
    localparam int NR    = 4;
    localparam int DEPTH = 8;
    localparam int IDW   = 3;
    localparam int TMO   = 16;

    logic              clk;
    logic              rst;
    logic              sched_enable;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_restore;
    logic [NR*IDW-1:0] req_slot;
    logic [NR-1:0]     req_ack;
    logic [NR-1:0]     rsp_valid;
    logic              rsp_ok;
    logic [IDW-1:0]    rsp_slot;
    logic              ckpt_trigger;
    logic              recov_trigger;
    logic [IDW-1:0]    ckpt_id;
    logic              ckpt_complete;
    logic              recov_complete;
    logic              ckpt_failed;
    logic              recov_failed;
    logic [DEPTH-1:0]  slot_valid;
    logic              busy;
    logic              timeout_err;
    logic [7:0]        fail_count;

    checkpoint_scheduler #(
        .NUM_REQ(NR), .CHECKPOINT_DEPTH(DEPTH), .ID_W(IDW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .sched_enable(sched_enable),
        .req_valid(req_valid), .req_restore(req_restore), .req_slot(req_slot),
        .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_ok(rsp_ok), .rsp_slot(rsp_slot),
        .ckpt_trigger(ckpt_trigger), .recov_trigger(recov_trigger), .ckpt_id(ckpt_id),
        .ckpt_complete(ckpt_complete), .recov_complete(recov_complete),
        .ckpt_failed(ckpt_failed), .recov_failed(recov_failed),
        .slot_valid(slot_valid), .busy(busy), .timeout_err(timeout_err), .fail_count(fail_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: slot occupancy, allocation pointer, per-class next-priority index, counters.
    bit m_valid [DEPTH];
    int m_wrptr;
    int m_next_rest;
    int m_next_save;
    int m_fail;
    bit m_terr;

    int n_checks;
    int n_errors;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DEPTH-1:0] model_slots();
        logic [DEPTH-1:0] v;
        for (int i = 0; i < DEPTH; i++) v[i] = m_valid[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        m_wrptr = 0; m_next_rest = 0; m_next_save = 0; m_fail = 0; m_terr = 1'b0;
    endtask

    function automatic int model_pick(output bit rest);
        rest = 1'b0;
        for (int k = 0; k < NR; k++) begin
            int i;
            i = (m_next_rest + k) % NR;
            if (req_valid[i] && req_restore[i]) begin rest = 1'b1; return i; end
        end
        for (int k = 0; k < NR; k++) begin
            int i;
            i = (m_next_save + k) % NR;
            if (req_valid[i] && !req_restore[i]) return i;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input bit restore, input int slot);
        req_valid[i]             = 1'b1;
        req_restore[i]           = restore;
        req_slot[i*IDW +: IDW]   = IDW'(slot);
    endtask

    task automatic clear_ctrl();
        ckpt_complete = 1'b0; recov_complete = 1'b0; ckpt_failed = 1'b0; recov_failed = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        req_valid = '0; req_restore = '0; req_slot = '0;
        clear_ctrl();
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Entered and left one time unit after a rising edge with the DUT in IDLE.
    // kind: 0 complete, 1 failed, 2 failed+complete, 3 silent controller.
    task automatic run_op(input int kind, input int done_at, input bit noise, input bit drop_en,
                          input int abort_at, output int gnt);
        bit rest;
        int g;
        int slot;
        int rcyc;
        bit exp_ok;
        bit exp_tmo;
        bit quiet_bad;
        logic [NR-1:0] oh;
        gnt = -1;
        g = model_pick(rest);
        if (g < 0) begin
            @(posedge clk); #1;
            check_eq("idle_nogrant", {busy, req_ack}, '0);
            return;
        end
        if (rest) m_next_rest = (g + 1) % NR; else m_next_save = (g + 1) % NR;
        slot = rest ? int'(req_slot[g*IDW +: IDW]) : m_wrptr;
        oh = NR'(1 << g);

        @(posedge clk); #1;
        for (int i = 0; i < NR; i++) if (req_ack[i]) gnt = i;
        check_eq("grant_ack", req_ack, oh);
        req_valid[g] = 1'b0;

        if (rest && !m_valid[slot]) begin
            check_eq("inv_rsp", {rsp_valid, rsp_ok, rsp_slot}, {oh, 1'b0, IDW'(slot)});
            check_eq("inv_notrig", {ckpt_trigger, recov_trigger}, '0);
            if (m_fail < 255) m_fail++;
            @(posedge clk); #1;
            check_eq("inv_idle", {busy, fail_count}, {1'b0, 8'(m_fail)});
            return;
        end

        check_eq("issue_trig", {ckpt_trigger, recov_trigger, ckpt_id}, {!rest, rest, IDW'(slot)});
        if (!rest) m_valid[slot] = 1'b0;
        check_eq("issue_slots", slot_valid, model_slots());
        if (noise) begin
            if (rest) recov_complete = 1'b1; else ckpt_complete = 1'b1;
        end
        if (drop_en) sched_enable = 1'b0;

        if (kind == 3) begin rcyc = TMO + 2; exp_ok = 1'b0; exp_tmo = 1'b1; end
        else begin rcyc = done_at + 1; exp_ok = (kind == 0); exp_tmo = 1'b0; end

        quiet_bad = 1'b0;
        for (int c = 2; c <= rcyc; c++) begin
            @(posedge clk); #1;
            clear_ctrl();
            if (abort_at == c) begin
                #2 rst = 1'b1;
                #1 check_eq("abort_clear", {busy, slot_valid, req_ack, rsp_valid, ckpt_trigger,
                                            recov_trigger, ckpt_id, fail_count, timeout_err}, '0);
                req_valid = '0; req_restore = '0; req_slot = '0;
                sched_enable = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                model_reset();
                return;
            end
            if (c < rcyc) begin
                if (rsp_valid != '0 || !busy || ckpt_id != IDW'(slot) || ckpt_trigger || recov_trigger)
                    quiet_bad = 1'b1;
                if (kind != 3 && c == done_at) begin
                    if (kind != 1) begin if (rest) recov_complete = 1'b1; else ckpt_complete = 1'b1; end
                    if (kind != 0) begin if (rest) recov_failed = 1'b1; else ckpt_failed = 1'b1; end
                end
                if (noise) begin
                    if (rest) begin ckpt_complete = 1'b1; ckpt_failed = 1'($urandom_range(0, 1)); end
                    else begin recov_complete = 1'b1; recov_failed = 1'($urandom_range(0, 1)); end
                end
            end
        end
        check_eq("wait_quiet", quiet_bad, 1'b0);
        check_eq("rsp", {rsp_valid, rsp_ok, rsp_slot}, {oh, exp_ok, IDW'(slot)});
        if (exp_ok && !rest) begin m_valid[slot] = 1'b1; m_wrptr = (m_wrptr + 1) % DEPTH; end
        if (!exp_ok && m_fail < 255) m_fail++;
        if (exp_tmo) m_terr = 1'b1;
        sched_enable = 1'b1;
        @(posedge clk); #1;
        check_eq("post_state", {busy, timeout_err, fail_count, slot_valid},
                 {1'b0, m_terr, 8'(m_fail), model_slots()});
    endtask

    task automatic hold_disabled(input int n);
        bit bad;
        bad = 1'b0;
        sched_enable = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            if (busy || req_ack != '0 || ckpt_trigger || recov_trigger) bad = 1'b1;
        end
        check_eq("disabled_no_grant", bad, 1'b0);
        sched_enable = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int g;
        int kind;
        int done_at;
        int r;
        n_checks = 0; n_errors = 0;
        rst = 1'b1; sched_enable = 1'b0;
        req_valid = '0; req_restore = '0; req_slot = '0;
        clear_ctrl();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_outputs", {busy, slot_valid, req_ack, rsp_valid, rsp_ok, rsp_slot, ckpt_trigger,
                                   recov_trigger, ckpt_id, fail_count, timeout_err}, '0);
        rst = 1'b0;
        sched_enable = 1'b1;

        // Single save, controller done at cycle 5.
        set_req(0, 1'b0, 0);
        run_op(0, 5, 1'b0, 1'b0, 0, g);
        check_eq("t1_grant", g, 0);
        check_eq("t1_slots", slot_valid, 8'h01);

        // Restore and save raised together: restore first.
        set_req(1, 1'b1, 0);
        set_req(2, 1'b0, 0);
        run_op(0, 2, 1'b1, 1'b0, 0, g);
        check_eq("t2_restore_first", g, 1);
        run_op(0, 3, 1'b0, 1'b0, 0, g);
        check_eq("t2_save_second", g, 2);

        // Restore of an empty slot.
        set_req(3, 1'b1, 5);
        run_op(0, 2, 1'b0, 1'b0, 0, g);
        check_eq("t3_fail_count", fail_count, 8'd1);

        // Complete on the timeout cycle wins, then a silent controller times out.
        set_req(0, 1'b0, 0);
        run_op(0, TMO + 1, 1'b0, 1'b0, 0, g);
        check_eq("t4_complete_wins", {timeout_err, slot_valid[2]}, 2'b01);
        set_req(1, 1'b0, 0);
        run_op(3, 0, 1'b0, 1'b1, 0, g);
        check_eq("t4_timeout", {timeout_err, slot_valid[3]}, 2'b10);

        // sched_enable low blocks grants.
        set_req(2, 1'b0, 0);
        hold_disabled(5);
        run_op(1, 4, 1'b1, 1'b0, 0, g);
        check_eq("t5_after_enable", g, 2);

        // Nine saves wrap and overwrite slot 0; a tenth lands on slot 1.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            if (k == 8) check_eq("t6_all_valid", slot_valid, 8'hFF);
            set_req(k % NR, 1'b0, 0);
            run_op(0, $urandom_range(2, 6), 1'b1, 1'b0, 0, g);
        end

        // All requesters saving continuously, reset during the fifth WAIT.
        do_reset();
        for (int k = 0; k < NR; k++) set_req(k, 1'b0, 0);
        for (int k = 0; k < NR; k++) begin
            run_op(0, 2, 1'b0, 1'b0, 0, g);
            check_eq("rr_order", g, k);
            if (g >= 0) set_req(g, 1'b0, 0);
        end
        run_op(0, 6, 1'b0, 1'b0, 4, g);
        check_eq("rr_wrap", g, 0);

        // fail_count saturates at 255.
        for (int k = 0; k < 260; k++) begin
            set_req(3, 1'b1, $urandom_range(0, DEPTH - 1));
            run_op(0, 2, 1'b0, 1'b0, 0, g);
        end
        check_eq("fail_saturate", fail_count, 8'hFF);

        // Randomized traffic.
        do_reset();
        for (int it = 0; it < 120; it++) begin
            for (int i = 0; i < NR; i++)
                if (!req_valid[i] && $urandom_range(0, 2) == 0)
                    set_req(i, 1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1));
            if (req_valid == '0) set_req($urandom_range(0, NR - 1), 1'b0, 0);
            if ($urandom_range(0, 7) == 0) hold_disabled($urandom_range(1, 4));
            r = $urandom_range(0, 9);
            kind = (r < 6) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : 3;
            done_at = (kind == 0 && $urandom_range(0, 7) == 0) ? TMO + 1 : $urandom_range(2, 7);
            run_op(kind, done_at, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, g);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/checkpoint_scheduler.md
# checkpoint_scheduler

Front-end scheduler for the checkpoint controller. It accepts save and restore requests from NUM_REQ requesters (hart software, watchdog, fault handler, auto-policy). It arbitrates between them, allocates checkpoint slot IDs and tracks which slots hold valid checkpoints. It then drives the controller's trigger/ID inputs one operation at a time and returns a per-requester completion response with timeout protection.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters
- CHECKPOINT_DEPTH, 8, number of checkpoint slots; must match the controller
- ID_W, $clog2(CHECKPOINT_DEPTH), slot ID width (derived)
- TIMEOUT_CYCLES, 4096, maximum cycles to wait for controller completion

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, asynchronous, active-high
- sched_enable  in  1  when 0, no new grants are issued; an in-flight operation still finishes
- req_valid  in  NUM_REQ  request pending; held until req_ack
- req_restore  in  NUM_REQ  1 = restore, 0 = save
- req_slot  in  NUM_REQ×ID_W  slot to restore; ignored for save
- req_ack  out  NUM_REQ  one-cycle pulse: request captured
- rsp_valid  out  NUM_REQ  one-cycle pulse: operation finished
- rsp_ok  out  1  qualifies rsp_valid; 1 = success
- rsp_slot  out  ID_W  slot that was saved or restored; qualifies rsp_valid
- ckpt_trigger  out  1  one-cycle save start to controller
- recov_trigger  out  1  one-cycle restore start to controller
- ckpt_id  out  ID_W  slot ID to controller; stable from the trigger cycle through WAIT
- ckpt_complete, recov_complete  in  1  controller done pulses
- ckpt_failed, recov_failed  in  1  controller failure pulses
- slot_valid  out  CHECKPOINT_DEPTH  slot holds a good checkpoint
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky; cleared only by reset
- fail_count  out  8  saturating count of failed, timed-out and invalid-slot operations

## Operation
- FSM states:
  - IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Requires sched_enable=1 and any req_valid to grant.
  - Restores have priority over saves. Within each class, round-robin starting after the last grant.
  - On a grant, latch grant index, type and slot.
  - Restore to a slot with slot_valid=0: go to RESP with ok=0, no trigger.
  - Otherwise go to ISSUE.
- Save slot allocation:
  - Slot = wr_ptr, a circular pointer.
  - wr_ptr advances mod CHECKPOINT_DEPTH only on a successful save.
  - When all slots are valid, the oldest slot is overwritten.
- ISSUE (1 cycle):
  - Pulse req_ack[grant] and the matching trigger; drive ckpt_id.
  - Clear slot_valid[slot] at trigger for a save.
  - Go to WAIT; the timeout counter resets to 0.
- WAIT:
  - Matching complete: ok=1. Matching failed: ok=0.
  - Counter reaching TIMEOUT_CYCLES-1: ok=0 and set timeout_err.
  - Exit to RESP on any of the above.
  - Inputs of the non-matching type are ignored.
- RESP (1 cycle):
  - Pulse rsp_valid[grant] with rsp_ok and rsp_slot.
  - Successful save: set slot_valid[slot] and advance wr_ptr.
  - ok=0: increment fail_count, saturating at 255.
  - Go to IDLE.
- Invalid-slot restore: req_ack pulses in the same RESP cycle as rsp_valid.
- Simultaneous events:
  - failed and complete in the same cycle: failed wins.
  - complete on the timeout cycle: complete wins.
  - complete/failed outside WAIT: ignored.
- sched_enable falling mid-operation has no effect on the current operation.

## Timing
- Reset values: all outputs 0; slot_valid=0, wr_ptr=0, round-robin pointer=0, state IDLE.
- Reset asserted mid-operation aborts immediately with no response pulse.
- Request sampled in IDLE at cycle 0:
  - cycle 1: ISSUE (ack + trigger)
  - WAIT from cycle 2
  - done seen at cycle N: rsp_valid at N+1
  - IDLE at N+2
- Minimum save/restore turnaround is 4 cycles, when done arrives at cycle 2.
- Invalid-slot restore: rsp at cycle 1, IDLE at cycle 2.
- A requester must deassert req_valid the cycle after req_ack. Otherwise its request is re-arbitrated as a new request.

## Structure
- Package checkpoint_sched_pkg holds:
  - the FSM state enum
  - the request-type enum
  - the default TIMEOUT_CYCLES constant
- Sub-module ckpt_rr_arbiter:
  - parameterized round-robin arbiter with an update-on-grant pointer
  - instantiated twice, once for the restore class and once for the save class

## Test plan
- Single save from req 0 with complete at cycle 5 → ckpt_trigger at cycle 1, ckpt_id=0, rsp_valid[0] at cycle 6 with ok=1, slot_valid=8'h01, wr_ptr=1.
- Req 1 restore slot 0 and req 2 save raised in the same cycle → restore granted first with recov_trigger and ckpt_id=0; save follows with ckpt_id=1.
- Restore of invalid slot 5 → no trigger, rsp_ok=0 at cycle 1, fail_count=1.
- Controller silent, TIMEOUT_CYCLES=16 → rsp_ok=0 at cycle 18, timeout_err=1, slot_valid bit cleared.
- Nine successful saves → ninth overwrites slot 0: slot_valid[0] is 0 during the operation and 1 after, wr_ptr=1.
- All four requesters saving continuously → grants in order 0,1,2,3,0; reset asserted during WAIT clears busy, slot_valid and the outputs asynchronously.
